// File: rtl/tap_lfsr_gen.sv
// Programmable Fibonacci LFSR byte generator.
// Latches a packed tap-index vector from the upstream selector and accepts a
// software seed one byte at a time. It then streams pseudo-random words over a
// valid/ready handshake.
module tap_lfsr_gen #(
   parameter int NUM_OF_TAPS = 15,
   parameter int TAP_W       = 8,
   parameter int LFSR_W      = 256,
   parameter int OUT_W       = 8
) (
   input  logic                         clk,
   input  logic                         res,
   input  logic [NUM_OF_TAPS*TAP_W-1:0] taps,
   input  logic                         taps_valid,
   input  logic [OUT_W-1:0]             seed_in,
   input  logic                         seed_we,
   input  logic                         start,
   output logic [OUT_W-1:0]             dout,
   output logic                         dout_valid,
   input  logic                         dout_ready,
   output logic                         busy,
   output logic                         err
);

   localparam int SEEDS = LFSR_W / OUT_W;
   localparam int SCW   = $clog2(SEEDS + 1);
   localparam int BCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   // ARM is the single cycle between an accepted start and RUN. Externally it
   // looks like LOAD (busy low), and it makes the first word appear OUT_W+1
   // edges after the edge that samples start.
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARM, S_RUN} st_e;

   st_e                          st_q, st_d;
   logic [LFSR_W-1:0]            lfsr_q, lfsr_d;
   logic [NUM_OF_TAPS*TAP_W-1:0] taps_q, taps_d;
   logic [SCW-1:0]               seed_cnt_q, seed_cnt_d;
   logic [BCW-1:0]               bit_cnt_q, bit_cnt_d;
   logic [OUT_W-1:0]             part_q, part_d;
   logic [OUT_W-1:0]             dout_q, dout_d;
   logic                         dval_q, dval_d;
   logic                         err_q, err_d;
   logic                         tv_q;

   logic                         tap_edge;
   logic                         step;
   logic                         fb;

   assign tap_edge   = taps_valid & ~tv_q;
   assign step       = ~dval_q | dout_ready;
   assign dout       = dout_q;
   assign dout_valid = dval_q;
   assign busy       = (st_q == S_RUN);
   assign err        = err_q;

   // Feedback bit: XOR of the selected state bits. Duplicate taps cancel in pairs.
   always_comb begin
      fb = 1'b0;
      for (int i = 0; i < NUM_OF_TAPS; i++)
         fb ^= lfsr_q[taps_q[i*TAP_W +: TAP_W]];
   end

   // Next-state logic for the FSM, seed loading, generation and tap capture.
   always_comb begin
      st_d       = st_q;
      lfsr_d     = lfsr_q;
      taps_d     = taps_q;
      seed_cnt_d = seed_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      part_d     = part_q;
      dout_d     = dout_q;
      dval_d     = dval_q;
      err_d      = 1'b0;

      case (st_q)
         S_LOAD: begin
            // start is judged against the counter and state before any
            // seed write in the same cycle.
            if (start) begin
               if (seed_cnt_q == SCW'(SEEDS) && lfsr_q != '0) st_d  = S_ARM;
               else                                          err_d = 1'b1;
            end
            if (seed_we) begin
               lfsr_d = {lfsr_q[LFSR_W-OUT_W-1:0], seed_in};
               if (seed_cnt_q != SCW'(SEEDS)) seed_cnt_d = seed_cnt_q + 1'b1;
            end
         end
         S_ARM: st_d = S_RUN;
         S_RUN: begin
            if (dval_q && dout_ready) dval_d = 1'b0;
            if (step) begin
               lfsr_d    = {lfsr_q[LFSR_W-2:0], fb};
               part_d    = {part_q[OUT_W-2:0], fb};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BCW'(OUT_W-1)) begin
                  dout_d    = {part_q[OUT_W-2:0], fb};
                  dval_d    = 1'b1;
                  bit_cnt_d = '0;
               end
            end
         end
         default: ;
      endcase

      // A fresh tap vector restarts the seeding procedure from any state.
      if (tap_edge) begin
         taps_d     = taps;
         seed_cnt_d = '0;
         bit_cnt_d  = '0;
         part_d     = '0;
         dval_d     = 1'b0;
         st_d       = S_LOAD;
      end
   end

   // State registers. On reset the edge detector takes the current taps_valid,
   // so a level held high through reset is not seen as a new edge.
   always_ff @(posedge clk) begin
      if (!res) begin
         st_q       <= S_IDLE;
         lfsr_q     <= '0;
         taps_q     <= '0;
         seed_cnt_q <= '0;
         bit_cnt_q  <= '0;
         part_q     <= '0;
         dout_q     <= '0;
         dval_q     <= 1'b0;
         err_q      <= 1'b0;
         tv_q       <= taps_valid;
      end else begin
         st_q       <= st_d;
         lfsr_q     <= lfsr_d;
         taps_q     <= taps_d;
         seed_cnt_q <= seed_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         part_q     <= part_d;
         dout_q     <= dout_d;
         dval_q     <= dval_d;
         err_q      <= err_d;
         tv_q       <= taps_valid;
      end
   end

endmodule
